// File: rtl/rel_mem_psum_loader.sv
// Psum reload path: reads spilled partial sums back from psum_gbf, rebuilds
// the full PE-array psum image one BRAM word at a time (MSB slice first),
// and presents each finished image to the pe_array psum register file.
// The BRAM address sequence and wrap rule mirror the psum write path.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; no reads issued
// S_READ  | one BRAM read per cycle, WORDS*RF_DEPTH reads back-to-back
// S_DRAIN | reads done; waiting for the last image to be delivered
// S_DONE  | single cycle, load_finish asserted
module rel_mem_psum_loader #(
  parameter int ROW                   = 16,
  parameter int COL                   = 16,
  parameter int DATA_BITWIDTH         = 16,
  parameter int GBF_DATA_BITWIDTH     = 512,
  parameter int PSUM_RF_ADDR_BITWIDTH = 2,
  parameter int BRAM_ADDR_BITWIDTH    = 10
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  start_i,
  input  logic [BRAM_ADDR_BITWIDTH-1:0]         sram_psum_num_i,
  input  logic [GBF_DATA_BITWIDTH-1:0]          gbf_rd_data_i,
  output logic                                  psum_read_en_o,
  output logic [BRAM_ADDR_BITWIDTH-1:0]         psum_BRAM_addr_o,
  output logic [DATA_BITWIDTH*ROW*COL-1:0]      psum_in_o,
  output logic [PSUM_RF_ADDR_BITWIDTH-1:0]      psum_rf_addr_o,
  output logic                                  psum_load_valid_o,
  output logic                                  busy_o,
  output logic                                  load_finish_o
);

  localparam int TOTAL     = DATA_BITWIDTH * ROW * COL;
  localparam int GBF       = GBF_DATA_BITWIDTH;
  localparam int WORDS     = TOTAL / GBF;
  localparam int RF_DEPTH  = 1 << PSUM_RF_ADDR_BITWIDTH;
  localparam int NUM_READS = WORDS * RF_DEPTH;
  localparam int WI_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W     = $clog2(NUM_READS + 1);
  localparam int AW        = BRAM_ADDR_BITWIDTH;
  localparam int RFW       = PSUM_RF_ADDR_BITWIDTH;

  localparam logic [WI_W-1:0]  LAST_WORD = WI_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_READ = CNT_W'(NUM_READS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              read_en;

  logic              rd_pending_q;
  logic [WI_W-1:0]   word_idx_q;
  logic [RFW-1:0]    rf_idx_q;
  logic              valid_q;
  logic [TOTAL-1:0]  psum_q;

  // State, read counter and BRAM address registers; address survives across loads.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      addr_q   <= addr_d;
    end
  end

  // Next-state, read issue and address advance with wrap at sram_psum_num.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    addr_d   = addr_q;
    read_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_READ;
          rd_cnt_d = '0;
        end
      end
      S_READ: begin
        read_en  = 1'b1;
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
        if (rd_cnt_q == LAST_READ) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // The only valid pulse seen in DRAIN is the final image.
        if (valid_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (read_en) begin
      if ((sram_psum_num_i <= AW'(1)) || (addr_q == sram_psum_num_i - AW'(1)))
        addr_d = '0;
      else
        addr_d = addr_q + AW'(1);
    end
  end

  // Capture returning BRAM words into the image and pulse valid when the image completes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_pending_q <= 1'b0;
      word_idx_q   <= '0;
      rf_idx_q     <= '0;
      valid_q      <= 1'b0;
      psum_q       <= '0;
    end else begin
      rd_pending_q <= read_en;
      valid_q      <= rd_pending_q && (word_idx_q == LAST_WORD);
      if (rd_pending_q) begin
        word_idx_q <= (word_idx_q == LAST_WORD) ? '0 : word_idx_q + WI_W'(1);
        for (int k = 0; k < WORDS; k++) begin
          if (word_idx_q == WI_W'(k))
            psum_q[TOTAL-1-k*GBF -: GBF] <= gbf_rd_data_i;
        end
      end
      if (valid_q) rf_idx_q <= rf_idx_q + RFW'(1);
    end
  end

  assign psum_read_en_o    = read_en;
  assign psum_BRAM_addr_o  = addr_q;
  assign psum_in_o         = psum_q;
  assign psum_rf_addr_o    = rf_idx_q;
  assign psum_load_valid_o = valid_q;
  assign busy_o            = (state_q != S_IDLE);
  assign load_finish_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_rel_mem_psum_loader.sv
// Bench for rel_mem_psum_loader: behavioural BRAM, scoreboard of expected
// read addresses and images, and per-scenario timing checks.
module tb_rel_mem_psum_loader;
  localparam int ROW = 16, COL = 16, DW = 16, GBF = 512, RFW = 2, AW = 10;
  localparam int TOTAL = ROW * COL * DW;
  localparam int WORDS = TOTAL / GBF;
  localparam int RFD   = 1 << RFW;
  localparam int N     = WORDS * RFD;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              start_i = 1'b0;
  logic [AW-1:0]     sram_psum_num_i = '0;
  logic [GBF-1:0]    gbf_rd_data_i = '0;
  logic              psum_read_en_o;
  logic [AW-1:0]     psum_BRAM_addr_o;
  logic [TOTAL-1:0]  psum_in_o;
  logic [RFW-1:0]    psum_rf_addr_o;
  logic              psum_load_valid_o;
  logic              busy_o;
  logic              load_finish_o;

  rel_mem_psum_loader #(
    .ROW(ROW), .COL(COL), .DATA_BITWIDTH(DW), .GBF_DATA_BITWIDTH(GBF),
    .PSUM_RF_ADDR_BITWIDTH(RFW), .BRAM_ADDR_BITWIDTH(AW)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
    .sram_psum_num_i(sram_psum_num_i), .gbf_rd_data_i(gbf_rd_data_i),
    .psum_read_en_o(psum_read_en_o), .psum_BRAM_addr_o(psum_BRAM_addr_o),
    .psum_in_o(psum_in_o), .psum_rf_addr_o(psum_rf_addr_o),
    .psum_load_valid_o(psum_load_valid_o), .busy_o(busy_o),
    .load_finish_o(load_finish_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard (expected) and observation logs
  logic [AW-1:0]    m_addr = '0;
  logic [AW-1:0]    exp_addr_q[$];
  logic [TOTAL-1:0] exp_img_q[$];
  logic [RFW-1:0]   exp_rf_q[$];
  int               rd_cyc_q[$];
  int               val_cyc_q[$];
  int               fin_cyc_q[$];

  function automatic logic [GBF-1:0] bram_word(input logic [AW-1:0] a);
    logic [31:0] e;
    e = {a, 22'h0};
    return {16{e}};
  endfunction

  // BRAM model: one-cycle read latency, junk when not reading
  always @(posedge clk_i)
    gbf_rd_data_i <= psum_read_en_o ? bram_word(psum_BRAM_addr_o)
                                    : {16{$urandom()}};

  // Monitor: pops expected values when the DUT produces reads / images
  always @(posedge clk_i) begin
    logic [AW-1:0]    ea;
    logic [TOTAL-1:0] ei;
    logic [RFW-1:0]   er;
    logic             shown;
    #3;
    if (!reset_i) begin
      if (psum_read_en_o) begin
        rd_cyc_q.push_back(cyc);
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_addr: unexpected read at cycle %0d addr %0d, required no read", cyc, psum_BRAM_addr_o);
        end else begin
          ea = exp_addr_q.pop_front();
          if (psum_BRAM_addr_o !== ea) begin
            n_err++;
            $display("FAIL rd_addr: cycle %0d got %0d required %0d", cyc, psum_BRAM_addr_o, ea);
          end
        end
      end
      if (psum_load_valid_o) begin
        val_cyc_q.push_back(cyc);
        n_cmp++;
        if (exp_img_q.size() == 0) begin
          n_err++;
          $display("FAIL image: unexpected valid at cycle %0d, required none", cyc);
        end else begin
          ei = exp_img_q.pop_front();
          er = exp_rf_q.pop_front();
          if (psum_rf_addr_o !== er || psum_in_o !== ei) begin
            n_err++;
            shown = 1'b0;
            $display("FAIL image: cycle %0d rf_addr got %0d required %0d", cyc, psum_rf_addr_o, er);
            for (int k = 0; k < WORDS; k++) begin
              if (!shown && psum_in_o[TOTAL-1-k*GBF -: GBF] !== ei[TOTAL-1-k*GBF -: GBF]) begin
                shown = 1'b1;
                $display("  slice %0d got %h required %h", k,
                         psum_in_o[TOTAL-1-k*GBF -: GBF], ei[TOTAL-1-k*GBF -: GBF]);
              end
            end
          end
        end
      end
      if (load_finish_o) fin_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_obs();
    rd_cyc_q.delete();
    val_cyc_q.delete();
    fin_cyc_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    exp_addr_q.delete();
    exp_img_q.delete();
    exp_rf_q.delete();
    m_addr = '0;
    clear_obs();
  endtask

  // Push the expected reads/images for one load, then pulse start.
  // Returns t = cycle in which start is high; ends at the negedge of t+1.
  task automatic run_load(input logic [AW-1:0] num, output int t);
    logic [TOTAL-1:0] img;
    img = '0;
    sram_psum_num_i = num;
    for (int j = 0; j < RFD; j++) begin
      for (int k = 0; k < WORDS; k++) begin
        exp_addr_q.push_back(m_addr);
        img[TOTAL-1-k*GBF -: GBF] = bram_word(m_addr);
        if (num <= 1 || m_addr == num - AW'(1)) m_addr = '0;
        else m_addr = m_addr + AW'(1);
      end
      exp_img_q.push_back(img);
      exp_rf_q.push_back(RFW'(j));
    end
    @(negedge clk_i);
    start_i = 1'b1;
    t = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if ({psum_read_en_o, psum_load_valid_o, busy_o, load_finish_o} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 0000", {psum_read_en_o, psum_load_valid_o, busy_o, load_finish_o});
    end
    n_cmp++;
    if (psum_BRAM_addr_o !== '0 || psum_rf_addr_o !== '0) begin
      n_err++;
      $display("FAIL reset_addr: bram %0d rf %0d required 0 0", psum_BRAM_addr_o, psum_rf_addr_o);
    end
    n_cmp++;
    if (psum_in_o !== '0) begin
      n_err++;
      $display("FAIL reset_psum_in: nonzero, required 0");
    end
    reset_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b0 || psum_read_en_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_start: busy %b rd_en %b required 0 0", busy_o, psum_read_en_o);
    end
  endtask

  // T1 + T2: timing of reads, valid pulses, finish; image content via scoreboard
  task automatic test_basic();
    int t;
    clear_obs();
    run_load(AW'(64), t);
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_start: got %b required 1", busy_o);
    end
    repeat (N + 6) @(negedge clk_i);
    n_cmp++;
    if (rd_cyc_q.size() != N) begin
      n_err++;
      $display("FAIL basic_reads: got %0d reads required %0d", rd_cyc_q.size(), N);
    end else begin
      n_cmp++;
      if (rd_cyc_q[0] != t + 1 || rd_cyc_q[N-1] != t + N) begin
        n_err++;
        $display("FAIL basic_read_window: got %0d..%0d required %0d..%0d", rd_cyc_q[0], rd_cyc_q[N-1], t + 1, t + N);
      end
    end
    n_cmp++;
    if (val_cyc_q.size() != RFD) begin
      n_err++;
      $display("FAIL basic_valids: got %0d required %0d", val_cyc_q.size(), RFD);
    end else begin
      for (int j = 0; j < RFD; j++) begin
        n_cmp++;
        if (val_cyc_q[j] != t + 1 + WORDS * (j + 1) + 1) begin
          n_err++;
          $display("FAIL basic_valid_cycle %0d: got %0d required %0d", j, val_cyc_q[j], t + 1 + WORDS * (j + 1) + 1);
        end
      end
    end
    n_cmp++;
    if (fin_cyc_q.size() != 1 || (fin_cyc_q.size() == 1 && fin_cyc_q[0] != t + N + 3)) begin
      n_err++;
      $display("FAIL basic_finish: count %0d cycle %0d required 1 at %0d", fin_cyc_q.size(),
               (fin_cyc_q.size() > 0) ? fin_cyc_q[0] : -1, t + N + 3);
    end
    n_cmp++;
    if (busy_o !== 1'b0 || exp_img_q.size() != 0 || exp_addr_q.size() != 0) begin
      n_err++;
      $display("FAIL basic_end: busy %b pending imgs %0d addrs %0d required 0 0 0", busy_o, exp_img_q.size(), exp_addr_q.size());
    end
  endtask

  // T4: start while busy and start on the load_finish cycle are dropped
  task automatic test_start_ignored();
    int t;
    clear_obs();
    run_load(AW'(64), t);
    repeat (6) @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    while (cyc < t + N + 3) @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (N + 8) @(negedge clk_i);
    n_cmp++;
    if (rd_cyc_q.size() != N || val_cyc_q.size() != RFD || fin_cyc_q.size() != 1) begin
      n_err++;
      $display("FAIL start_ignored: reads %0d valids %0d finishes %0d required %0d %0d 1",
               rd_cyc_q.size(), val_cyc_q.size(), fin_cyc_q.size(), N, RFD);
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL start_ignored_idle: busy %b required 0", busy_o);
    end
  endtask

  // T5: reset in the middle of READ aborts, then a fresh load starts at addr 0
  task automatic test_reset_mid();
    int t;
    do_reset();
    run_load(AW'(64), t);
    while (cyc < t + 15) @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i);
    #3;
    n_cmp++;
    if ({psum_read_en_o, psum_load_valid_o, busy_o, load_finish_o} !== 4'b0 ||
        psum_BRAM_addr_o !== '0 || psum_rf_addr_o !== '0 || psum_in_o !== '0) begin
      n_err++;
      $display("FAIL reset_mid: rd_en %b valid %b busy %b fin %b addr %0d rf %0d required all 0",
               psum_read_en_o, psum_load_valid_o, busy_o, load_finish_o, psum_BRAM_addr_o, psum_rf_addr_o);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    exp_addr_q.delete();
    exp_img_q.delete();
    exp_rf_q.delete();
    m_addr = '0;
    clear_obs();
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (rd_cyc_q.size() != 0 || val_cyc_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_quiet: reads %0d valids %0d required 0 0", rd_cyc_q.size(), val_cyc_q.size());
    end
    run_load(AW'(64), t);
    repeat (N + 6) @(negedge clk_i);
    n_cmp++;
    if (rd_cyc_q.size() != N || rd_cyc_q[0] != t + 1 || fin_cyc_q.size() != 1 || val_cyc_q.size() != RFD) begin
      n_err++;
      $display("FAIL reset_mid_reload: reads %0d valids %0d finishes %0d required %0d %0d 1",
               rd_cyc_q.size(), val_cyc_q.size(), fin_cyc_q.size(), N, RFD);
    end
  endtask

  // T3: sram_psum_num=40, two back-to-back loads; second load wraps 39 -> 0
  task automatic test_back_to_back();
    int t1, t2;
    do_reset();
    run_load(AW'(40), t1);
    while (cyc < t1 + N + 4) @(negedge clk_i);
    clear_obs();
    run_load(AW'(40), t2);
    n_cmp++;
    if (t2 != t1 + N + 5) begin
      n_err++;
      $display("FAIL b2b_start_cycle: got %0d required %0d", t2, t1 + N + 5);
    end
    repeat (N + 6) @(negedge clk_i);
    n_cmp++;
    if (rd_cyc_q.size() != N || val_cyc_q.size() != RFD || fin_cyc_q.size() != 1) begin
      n_err++;
      $display("FAIL b2b_counts: reads %0d valids %0d finishes %0d required %0d %0d 1",
               rd_cyc_q.size(), val_cyc_q.size(), fin_cyc_q.size(), N, RFD);
    end
    n_cmp++;
    if (psum_BRAM_addr_o !== AW'(24)) begin
      n_err++;
      $display("FAIL b2b_final_addr: got %0d required 24", psum_BRAM_addr_o);
    end
  endtask

  // T6: sram_psum_num=1 keeps every read at addr 0
  task automatic test_num_one();
    int t;
    do_reset();
    run_load(AW'(1), t);
    repeat (N + 6) @(negedge clk_i);
    n_cmp++;
    if (rd_cyc_q.size() != N || val_cyc_q.size() != RFD || exp_img_q.size() != 0) begin
      n_err++;
      $display("FAIL num_one: reads %0d valids %0d left %0d required %0d %0d 0",
               rd_cyc_q.size(), val_cyc_q.size(), exp_img_q.size(), N, RFD);
    end
    n_cmp++;
    if (psum_BRAM_addr_o !== '0) begin
      n_err++;
      $display("FAIL num_one_addr: got %0d required 0", psum_BRAM_addr_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_num_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
